// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall, busywait freeze and deferred branch flush.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module hazard_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic                  ID_USES_RS1,
  input  logic                  ID_USES_RS2,
  input  logic [REG_ADDR_W-1:0] EX_RD,
  input  logic                  EX_MEM_READ,
  input  logic                  BRANCH_TAKEN,
  input  logic                  IMEM_BUSYWAIT,
  input  logic                  DMEM_BUSYWAIT,
  output logic                  PIPE_BUSYWAIT,
  output logic                  PC_STALL,
  output logic                  IF_ID_STALL,
  output logic                  ID_EX_BUBBLE,
  output logic                  IF_ID_FLUSH,
  output logic                  ID_EX_FLUSH,
  output logic [CNT_W-1:0]      LU_STALL_CNT,
  output logic [CNT_W-1:0]      FLUSH_CNT,
  output logic [CNT_W-1:0]      FREEZE_CNT
);

  // state         | meaning
  // ST_RUN        | normal operation, no flush owed
  // ST_FLUSH_PEND | taken branch arrived during a freeze; flush once the freeze drops
  localparam logic [0:0] ST_RUN        = 1'b0;
  localparam logic [0:0] ST_FLUSH_PEND = 1'b1;

  logic [0:0] state_q, state_d;
  logic       freeze, lu;
  logic       busy, stall, flush;

  always_comb begin
    freeze = IMEM_BUSYWAIT | DMEM_BUSYWAIT;
    lu     = EX_MEM_READ && (EX_RD != '0) &&
             ((ID_USES_RS1 && (ID_RS1 == EX_RD)) || (ID_USES_RS2 && (ID_RS2 == EX_RD)));
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          busy = 1'b1;
          if (BRANCH_TAKEN) state_d = ST_FLUSH_PEND;
        end else if (BRANCH_TAKEN) begin
          flush = 1'b1;
        end else if (lu) begin
          stall = 1'b1;
        end
      end
      ST_FLUSH_PEND: begin
        if (freeze) begin
          busy = 1'b1;
        end else begin
          flush   = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    // Outputs are forced low while reset is held, even between clock edges.
    if (RESET) begin
      busy  = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  assign PIPE_BUSYWAIT = busy;
  assign PC_STALL      = stall;
  assign IF_ID_STALL   = stall;
  assign ID_EX_BUBBLE  = stall;
  assign IF_ID_FLUSH   = flush;
  assign ID_EX_FLUSH   = flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

  // Saturating increments: a counter at all-ones stays there.
  always_comb begin
    lu_cnt_d     = lu_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (stall && (lu_cnt_q != '1))     lu_cnt_d     = lu_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1))  flush_cnt_d  = flush_cnt_q + CNT_W'(1);
    if (busy && (freeze_cnt_q != '1))  freeze_cnt_d = freeze_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lu_cnt_q     <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      lu_cnt_q     <= lu_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign LU_STALL_CNT = lu_cnt_q;
  assign FLUSH_CNT    = flush_cnt_q;
  assign FREEZE_CNT   = freeze_cnt_q;
`else
  assign LU_STALL_CNT = '0;
  assign FLUSH_CNT    = '0;
  assign FREEZE_CNT   = '0;
`endif

endmodule
